// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-level round-robin arbiter that merges two byte
// streams (control replies on s0, tape readback on s1) onto one Ethernet
// TX MAC interface. Whole frames are granted, an inter-frame gap is
// enforced, and frames longer than MAX_LEN are cut and their tail drained.
module eth_tx_arbiter #(
   parameter int IFG_CYCLES = 12,
   parameter int MAX_LEN    = 1518
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s0_data,
   input  logic        s0_valid,
   input  logic        s0_last,
   output logic        s0_ready,
   input  logic [7:0]  s1_data,
   input  logic        s1_valid,
   input  logic        s1_last,
   output logic        s1_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        tx_last,
   input  logic        tx_ready,
   output logic [1:0]  grant,
   output logic        trunc_err,
   output logic [15:0] frame_count
);

   localparam int CW = $clog2(MAX_LEN + 1);
   localparam int GW = $clog2(IFG_CYCLES + 2);

   // Counter value while the MAX_LEN-th beat is on the bus.
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_LEN - 1);
   // Gap counter value in the final gap cycle.
   localparam logic [GW-1:0] GAP_END   = GW'(IFG_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2,
      GAP   = 2'd3
   } state_t;

   // With no gap configured a finished frame returns straight to arbitration.
   localparam state_t AFTER_FRAME = (IFG_CYCLES == 0) ? IDLE : GAP;

   state_t        state_q;
   logic [1:0]    grant_q;
   logic          last_q;        // 1'b0: s0 was granted last, 1'b1: s1
   logic [CW-1:0] byte_cnt_q;
   logic [GW-1:0] gap_cnt_q;
   logic          trunc_err_q;
   logic [15:0]   frame_count_q;

   logic [7:0]    sel_data;
   logic          sel_valid;
   logic          sel_last;
   logic          at_max;
   logic          beat;
   logic          pick_s1;

   // Select the granted source and derive beat, length-cap and arbitration terms
   always_comb begin
      if (grant_q[1]) begin
         sel_data  = s1_data;
         sel_valid = s1_valid;
         sel_last  = s1_last;
      end else begin
         sel_data  = s0_data;
         sel_valid = s0_valid;
         sel_last  = s0_last;
      end
      at_max = (byte_cnt_q == LAST_BEAT);
      beat   = (state_q == SEND) && sel_valid && tx_ready;
      // On a tie the source that did not own the previous frame wins.
      if (s0_valid && s1_valid) begin
         pick_s1 = ~last_q;
      end else begin
         pick_s1 = s1_valid;
      end
   end

   // Route the granted source to the MAC and steer ready back to it
   always_comb begin
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      case (state_q)
         SEND: begin
            tx_data  = sel_data;
            tx_valid = sel_valid;
            // The MAX_LEN-th beat is marked last even if the source is not done.
            tx_last  = sel_valid && (sel_last || at_max);
            s0_ready = grant_q[0] && tx_ready;
            s1_ready = grant_q[1] && tx_ready;
         end
         DRAIN: begin
            // Swallow the remainder of a truncated frame at full rate.
            s0_ready = grant_q[0];
            s1_ready = grant_q[1];
         end
         default: begin
            tx_data  = 8'h00;
            tx_valid = 1'b0;
         end
      endcase
   end

   // Frame-level arbitration FSM with registered grant, error pulse and frame count
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         grant_q       <= 2'b00;
         last_q        <= 1'b1;
         byte_cnt_q    <= '0;
         gap_cnt_q     <= '0;
         trunc_err_q   <= 1'b0;
         frame_count_q <= 16'h0000;
      end else begin
         trunc_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s0_valid || s1_valid) begin
                  grant_q    <= pick_s1 ? 2'b10 : 2'b01;
                  last_q     <= pick_s1;
                  byte_cnt_q <= '0;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (beat) begin
                  byte_cnt_q <= byte_cnt_q + CW'(1);
                  if (sel_last) begin
                     frame_count_q <= frame_count_q + 16'd1;
                     grant_q       <= 2'b00;
                     gap_cnt_q     <= '0;
                     state_q       <= AFTER_FRAME;
                  end else if (at_max) begin
                     frame_count_q <= frame_count_q + 16'd1;
                     trunc_err_q   <= 1'b1;
                     state_q       <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (sel_valid && sel_last) begin
                  grant_q   <= 2'b00;
                  gap_cnt_q <= '0;
                  state_q   <= AFTER_FRAME;
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_END) begin
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign trunc_err   = trunc_err_q;
   assign frame_count = frame_count_q;

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 12: idle cycles forced between consecutive frames on tx (0 allowed).
REQ-002 Parameter MAX_LEN, default 1518: maximum bytes per frame before forced truncation (≥2).
REQ-003 clk  in  1  single clock for all logic (125 MHz Ethernet clock).
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 s0_data  in  8  source 0 (control/status replies) byte.
REQ-006 s0_valid  in  1  source 0 byte valid.
REQ-007 s0_last  in  1  source 0 final byte of frame.
REQ-008 s0_ready  out  1  source 0 byte accepted when high with s0_valid.
REQ-009 s1_data, s1_valid, s1_last  in  8/1/1  source 1 (tape readback data), same meaning as source 0.
REQ-010 s1_ready  out  1  source 1 byte accepted.
REQ-011 tx_data  out  8  byte to Ethernet TX MAC.
REQ-012 tx_valid  out  1  tx_data valid.
REQ-013 tx_last  out  1  final byte of frame.
REQ-014 tx_ready  in  1  MAC accepts byte when high with tx_valid.
REQ-015 grant  out  2  one-hot current owner (bit0=s0, bit1=s1), 00 when none.
REQ-016 trunc_err  out  1  one-cycle pulse when a frame is truncated at MAX_LEN.
REQ-017 frame_count  out  16  count of frames completed on tx.

Function
REQ-018 States SHALL be IDLE, SEND, DRAIN, GAP; only frames are arbitrated, never individual bytes.
REQ-019 IDLE: if exactly one sX_valid high, grant it; if both high, grant the source not granted last (round-robin); transition to SEND on the next clock with grant registered.
REQ-020 Latency: source valid sampled in IDLE at edge N yields grant and tx_valid (if source still valid) in cycle N+1; no byte is accepted while in IDLE.
REQ-021 SEND: tx_data/tx_valid/tx_last combinationally follow the granted source; granted sX_ready = tx_ready; non-granted sX_ready = 0.
REQ-022 A beat transfers only when tx_valid && tx_ready; byte counter increments per beat, cleared on entry to SEND.
REQ-023 SEND: beat with source last -> GAP (or IDLE if IFG_CYCLES=0); frame_count increments, wrapping 0xFFFF->0x0000.
REQ-024 SEND: beat number MAX_LEN without source last -> tx_last forced high on that beat, trunc_err pulses next cycle, frame_count increments, state -> DRAIN.
REQ-025 Beat number MAX_LEN that also carries source last is a normal frame end: no trunc_err, no DRAIN.
REQ-026 DRAIN: granted sX_ready = 1, tx_valid = 0; source bytes discarded until a beat with sX_last, then -> GAP (or IDLE if IFG_CYCLES=0).
REQ-027 GAP: tx_valid = 0, all sX_ready = 0, grant = 00; lasts exactly IFG_CYCLES cycles, then IDLE.
REQ-028 Last-grant record updates at each grant; the waiting source wins the next arbitration after a frame by the other.
REQ-029 tx_ready low in SEND stalls without loss; source valid dropping mid-frame drops tx_valid but keeps grant.
REQ-030 grant SHALL be stable for an entire frame, including DRAIN.

Reset
REQ-031 On rst low at a clock edge: state IDLE, grant 00, tx_valid 0, tx_last 0, tx_data 0x00, s0_ready 0, s1_ready 0, trunc_err 0, frame_count 0, byte counter 0, gap counter 0, last-grant = s1 (s0 wins first tie).
REQ-032 Reset mid-frame abandons the frame with no tx_last; tx_valid is 0 the cycle after reset sampled low.

Verification
REQ-033 Both sources valid in the same cycle after reset, 4-byte frames, tx_ready=1 -> s0 frame first, 12 gap cycles, then s1 frame; frame_count=2.
REQ-034 s0 streams back-to-back 3-byte frames while s1 waits -> strict alternation s0,s1,s0 from the first contention.
REQ-035 MAX_LEN=8, s1 sends 12-byte frame -> tx carries 8 bytes with tx_last on byte 8, trunc_err one pulse, bytes 9-12 consumed with tx_valid=0, frame_count=1.
REQ-036 tx_ready toggled 1/0 every cycle on a 6-byte frame -> all 6 bytes in order, no duplicates, s0_ready mirrors tx_ready.
REQ-037 rst low during byte 3 of a 10-byte frame -> next cycle all outputs at reset values; a new frame after release is arbitrated with s0 priority.
REQ-038 IFG_CYCLES=0, single source back-to-back 2-byte frames -> exactly one IDLE cycle between tx_last and next tx_valid.
